// File: rtl/hunt_the_bit_arena_pkg.sv
// hunt_pkg: shared state encoding, rotate helper and BCD digit width for the hunt-the-bit core
package hunt_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int MAX_W = 64;
  typedef enum logic [2:0] {GAME_START, WAITING, HIT, MISS, ROTATE, LOSE_A, LOSE_B} state_t;
  // vec must be zero above bit w-1; dir=1 rotates toward the MSB
  function automatic logic [MAX_W-1:0] rot1(input logic [MAX_W-1:0] vec, input int w, input logic dir);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return dir ? ((vec << 1) | (vec >> (w - 1))) & mask : ((vec >> 1) | (vec << (w - 1))) & mask;
  endfunction
endpackage

// File: rtl/hunt_the_bit_arena_bcd_counter.sv
// bcd_counter: saturating packed-BCD up counter, digit 0 in the low nibble
module bcd_counter
  import hunt_pkg::*;
#(
  parameter int Digits = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inc,
  output logic [BCD_DIGIT_W*Digits-1:0]  value
);
  logic [Digits-1:0] nine;
  logic [Digits:0] carry;
  logic [BCD_DIGIT_W*Digits-1:0] value_n;
  for (genvar i = 0; i < Digits; i++) begin : g_nine
    assign nine[i] = value[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9;
  end
  always_comb begin
    carry = '0;
    value_n = value;
    carry[0] = inc & ~&nine;
    for (int i = 0; i < Digits; i++) begin
      carry[i+1] = carry[i] & nine[i];
      value_n[i*BCD_DIGIT_W +: BCD_DIGIT_W] = carry[i] ? (nine[i] ? 4'd0 : value[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1)
                                                       : value[i*BCD_DIGIT_W +: BCD_DIGIT_W];
    end
  end
  always_ff @(posedge clk) value <= rst ? '0 : value_n;
endmodule

// File: rtl/hunt_the_bit_arena.sv
// hunt_the_bit_arena: rotating-LED reaction game with lives, speed-up floor and saturating BCD score
module hunt_the_bit_arena
  import hunt_pkg::*;
#(
  parameter int                 Width        = 16,
  parameter int                 ClockFreqHz  = 50_000_000,
  parameter logic [Width-1:0]   StartPattern = Width'(16'h0F00),
  parameter int                 MaxPeriod    = ClockFreqHz / 4,
  parameter int                 MinPeriod    = MaxPeriod / 64,
  parameter int                 Lives        = 3,
  parameter int                 FlashPeriod  = ClockFreqHz / 8,
  parameter int                 Digits       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [Width-1:0]               button,
  input  logic                           dir,
  output logic [Width-1:0]               led,
  output logic [BCD_DIGIT_W*Digits-1:0]  points,
  output logic [3:0]                     lives,
  output logic                           game_over
);
  localparam int CW = $clog2(MaxPeriod > FlashPeriod ? MaxPeriod : FlashPeriod);
  localparam int PW = $clog2(MaxPeriod + 1);
  state_t state, state_n;
  logic [Width-1:0] led_state, btn_q, hit_q, pressed, hit_mask, cleared;
  logic [PW-1:0] period, half;
  logic [CW-1:0] cnt;
  logic [3:0] lives_q;
  logic miss, hit, multi, timeout, flash_end, lose;
  assign pressed = state == WAITING ? button & ~btn_q : '0;
  assign hit_mask = led_state & pressed;
  assign miss = |(pressed & ~led_state);
  assign hit = ~miss & |hit_mask;
  assign multi = |(led_state & (led_state - Width'(1)));
  assign cleared = led_state & ~hit_q;
  assign half = period >> 1;
  assign timeout = int'(cnt) == int'(period) - 1;
  assign flash_end = int'(cnt) == FlashPeriod - 1;
  assign lose = state == LOSE_A || state == LOSE_B;
  always_comb begin
    state_n = state == GAME_START ? WAITING :
              state == WAITING    ? (miss ? MISS : hit ? HIT : timeout ? ROTATE : WAITING) :
              state == HIT        ? ROTATE :
              state == MISS       ? (lives_q == 4'd1 ? LOSE_A : ROTATE) :
              state == ROTATE     ? WAITING :
              state == LOSE_A     ? (flash_end ? LOSE_B : LOSE_A) :
                                    (flash_end ? LOSE_A : LOSE_B);
  end
  always_ff @(posedge clk) begin
    state <= rst ? GAME_START : state_n;
    cnt <= rst || state_n != state ? '0 : cnt + CW'(1);
    btn_q <= rst ? '0 : button;
  end
  // hit_q holds the last WAITING hit mask so HIT can clear exactly those LEDs
  always_ff @(posedge clk)
    if (rst) hit_q <= '0;
    else if (state == WAITING) hit_q <= hit_mask;
  always_ff @(posedge clk)
    if (rst) led_state <= '0;
    else if (state == GAME_START) led_state <= StartPattern;
    else if (state == HIT && multi) led_state <= cleared == '0 ? hit_q & -hit_q : cleared;
    else if (state == ROTATE) led_state <= Width'(rot1(MAX_W'(led_state), Width, dir));
  always_ff @(posedge clk)
    if (rst) period <= PW'(MaxPeriod);
    else if (state == HIT && !multi) period <= half < PW'(MinPeriod) ? PW'(MinPeriod) : half;
  always_ff @(posedge clk)
    if (rst) lives_q <= 4'(Lives);
    else if (state == MISS && lives_q != 4'd0) lives_q <= lives_q - 4'd1;
  bcd_counter #(.Digits(Digits)) u_score (
    .clk  (clk),
    .rst  (rst),
    .inc  (state == HIT),
    .value(points)
  );
  assign led = rst || state == GAME_START ? StartPattern :
               state == LOSE_A            ? '1 :
               state == LOSE_B            ? '0 : led_state;
  assign lives = lives_q;
  assign game_over = ~rst & lose;
endmodule

// File: tb/tb_hunt_the_bit_arena.sv
// tb_hunt_the_bit_arena: scoreboard bench with a game-level reference model and a 1-digit twin for saturation
module tb_hunt_the_bit_arena;
  localparam int W = 8, MAXP = 16, MINP = 4, LV = 2, FL = 4;
  localparam logic [7:0] START = 8'h0F;
  logic clk = 0, rst = 1, dir = 0;
  logic [7:0] button = 0, led, led1;
  logic [31:0] points;
  logic [3:0] points1, lives, lives1;
  logic game_over, game_over1;
  hunt_the_bit_arena #(.Width(W), .StartPattern(START), .MaxPeriod(MAXP), .MinPeriod(MINP),
                       .Lives(LV), .FlashPeriod(FL), .Digits(8)) dut (
    .clk(clk), .rst(rst), .button(button), .dir(dir),
    .led(led), .points(points), .lives(lives), .game_over(game_over));
  hunt_the_bit_arena #(.Width(W), .StartPattern(START), .MaxPeriod(MAXP), .MinPeriod(MINP),
                       .Lives(LV), .FlashPeriod(FL), .Digits(1)) dut_sat (
    .clk(clk), .rst(rst), .button(button), .dir(dir),
    .led(led1), .points(points1), .lives(lives1), .game_over(game_over1));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  led;
    logic [31:0] pts;
    logic [3:0]  pts1;
    logic [3:0]  lives;
    logic        go;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  string ph = "start";
  int leds = 0, period = MAXP, score = 0, mlives = LV, cnt = 0, prev = 0, hm = 0;
  function automatic logic [31:0] bcd(input int v);
    logic [31:0] r = 0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // one clock of the game, described in terms of phases and LED arithmetic
  task automatic step(input logic r, input logic [7:0] b, input logic d);
    string nx;
    int pressed;
    if (r) begin
      ph = "start"; leds = 0; period = MAXP; score = 0; mlives = LV; cnt = 0; prev = 0;
      return;
    end
    nx = ph;
    pressed = (ph == "wait") ? (int'(b) & ~prev & 255) : 0;
    if (ph == "start") begin
      leds = START; nx = "wait";
    end else if (ph == "wait") begin
      if ((pressed & ~leds) != 0) nx = "miss";
      else if ((pressed & leds) != 0) begin nx = "hit"; hm = pressed & leds; end
      else if (cnt == period - 1) nx = "rot";
    end else if (ph == "hit") begin
      if ($countones(leds) > 1) begin
        leds = leds & ~hm;
        if (leds == 0) leds = hm & -hm;
      end else period = (period / 2 < MINP) ? MINP : period / 2;
      if (score < 99999999) score++;
      nx = "rot";
    end else if (ph == "miss") begin
      nx = (mlives == 1) ? "on" : "rot";
      if (mlives > 0) mlives--;
    end else if (ph == "rot") begin
      leds = d ? (((leds << 1) | (leds >> 7)) & 255) : (((leds >> 1) | (leds << 7)) & 255);
      nx = "wait";
    end else if (cnt == FL - 1) nx = (ph == "on") ? "off" : "on";
    cnt = (nx == ph) ? cnt + 1 : 0;
    ph = nx;
    prev = int'(b);
  endtask
  task automatic tick(input logic r, input logic [7:0] b, input logic d);
    exp_t e;
    rst = r; button = b; dir = d;
    e.led = (r || ph == "start") ? START : (ph == "on") ? 8'hFF : (ph == "off") ? 8'h00 : 8'(leds);
    e.pts = bcd(score);
    e.pts1 = 4'(score > 9 ? 9 : score);
    e.lives = 4'(mlives);
    e.go = !r && (ph == "on" || ph == "off");
    q.push_back(e);
    @(posedge clk);
    step(r, b, d);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, want);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("led", 32'(led), 32'(e.led));
      chk("points", points, e.pts);
      chk("lives", 32'(lives), 32'(e.lives));
      chk("game_over", 32'(game_over), 32'(e.go));
      chk("sat_points", 32'(points1), 32'(e.pts1));
    end
  end
  task automatic reach(input string p);
    int n = 0;
    while (ph != p && n < 200) begin tick(0, 0, dir); n++; end
    if (ph != p) begin
      total++; bad++;
      $display("FAIL reach_%s: got phase %s after %0d cycles", p, ph, n);
    end
  endtask
  // 0: lowest lit, 1: all lit, 2: lit plus an unlit bit, 3: fixed 0x11
  task automatic press(input int kind);
    int m, u;
    reach("wait");
    u = ~leds & 255;
    m = kind == 0 ? (leds & -leds) : kind == 1 ? leds : kind == 2 ? ((leds & -leds) | (u & -u)) : 'h11;
    tick(0, 8'(m), dir);
    tick(0, 0, dir);
  endtask
  initial begin
    int lt = 0;
    @(posedge clk); #1;
    tick(1, 0, 0);
    repeat (40) tick(0, 0, 0);
    tick(1, 0, 0);
    press(0);
    repeat (20) tick(0, 0, 0);
    press(1);
    repeat (11) press(0);
    repeat (10) tick(0, 0, 1);
    tick(1, 0, 0);
    reach("rot");
    repeat (20) tick(0, 8'h01, 0);
    tick(0, 0, 0);
    repeat (5) press(0);
    tick(1, 0, 0);
    press(3);
    press(2);
    repeat (20) tick(0, 0, 0);
    reach("off");
    tick(1, 0, 0);
    repeat (5) tick(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int k;
      logic [7:0] b;
      k = $urandom_range(0, 9);
      b = k == 0 ? 8'($urandom) : (k < 4 && ph == "wait") ? 8'(leds & -leds) : (k == 4) ? button : 8'h00;
      lt = (ph == "on" || ph == "off") ? lt + 1 : 0;
      tick(($urandom_range(0, 599) == 0) || lt > 12, b, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
